// File: rtl/hb_decim_filter.sv
// Half-band decimate-by-2 FIR. One pre-add/multiply/accumulate step per cycle, NCH interleaved
// channels, round-half-up, saturation with flag, valid/ready input and a bypass path.
module hb_decim_filter #(
    parameter int                    DW    = 35,
    parameter int                    CW    = 31,
    parameter int                    NSYM  = 19,
    parameter logic [NSYM*CW-1:0]    COEF  = '0,
    parameter logic signed [CW-1:0]  CTR   = {2'b01, {(CW-2){1'b0}}},
    parameter int                    SHIFT = 30,
    parameter int                    NCH   = 1,
    localparam int                   CHW   = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 byp,
    input  logic                 vld_in,
    output logic                 rdy_in,
    input  logic signed [DW-1:0] dat_in,
    output logic                 vld_out,
    output logic signed [DW-1:0] dat_out,
    output logic [CHW-1:0]       ch_out,
    output logic                 sat_out
);

    localparam int L  = 4*NSYM - 1;
    localparam int KW = $clog2(NSYM + 1);
    localparam int NT = NSYM + 1;
    localparam int HN = 1 << CHW;
    localparam int PW = DW + CW + 1;
    localparam int AW = DW + 1 + CW + KW;
    localparam int RW = AW + 1;
    localparam logic signed [RW-1:0] RND  = {{(RW-1){1'b0}}, 1'b1} << (SHIFT - 1);
    localparam logic signed [RW-1:0] MAXV = {{(RW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [RW-1:0] MINV = {{(RW-DW+1){1'b1}}, {(DW-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_BYP  = 2'd2,
        ST_OUT  = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic                  rdy_q, rdy_d;
    logic [KW-1:0]         k_q, k_d;
    logic signed [AW-1:0]  acc_q, acc_d;
    logic [CHW-1:0]        ch_q, ch_d, mch_q, mch_d, cho_q, cho_d;
    logic                  ph_q, ph_d, bmode_q, bmode_d, vld_q, vld_d, sat_q, sat_d;
    logic signed [DW-1:0]  bdat_q, bdat_d, dat_q, dat_d;
    logic signed [DW-1:0]  hist_q [HN][L];
    logic signed [DW-1:0]  hist_d [HN][L];
    logic signed [DW-1:0]  row_s [L];
    logic signed [DW:0]    op_a_s [NT];
    logic signed [CW-1:0]  op_b_s [NT];
    logic signed [PW-1:0]  prod_s;
    logic signed [RW-1:0]  rnd_s;
    logic                  accept_s;

    assign rdy_in   = rdy_q & ~rst;
    assign accept_s = vld_in & rdy_in;

    always_comb row_s = hist_q[mch_q];

    // Operand table: entry i is the symmetric pair sum and c_i; the last entry is the center tap.
    for (genvar i = 0; i < NSYM; i++) begin : g_pair
        assign op_a_s[i] = (DW+1)'(row_s[2*i]) + (DW+1)'(row_s[L-1-2*i]);
        assign op_b_s[i] = COEF[i*CW +: CW];
    end
    assign op_a_s[NSYM] = (DW+1)'(row_s[2*NSYM-1]);
    assign op_b_s[NSYM] = CTR;

    assign prod_s = PW'(op_a_s[k_q]) * PW'(op_b_s[k_q]);
    assign rnd_s  = (RW'(acc_q) + RND) >>> SHIFT;

    always_comb begin
        state_d = state_q;
        rdy_d   = rdy_q;
        k_d     = k_q;
        acc_d   = acc_q;
        ch_d    = ch_q;
        mch_d   = mch_q;
        cho_d   = cho_q;
        ph_d    = ph_q;
        bmode_d = bmode_q;
        bdat_d  = bdat_q;
        dat_d   = dat_q;
        sat_d   = sat_q;
        vld_d   = 1'b0;
        hist_d  = hist_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    mch_d = ch_q;
                    if (byp) begin
                        // Bypass leaves history, channel and phase untouched.
                        bdat_d  = dat_in;
                        bmode_d = 1'b1;
                        rdy_d   = 1'b0;
                        state_d = ST_BYP;
                    end else begin
                        for (int j = L-1; j > 0; j--) begin
                            hist_d[ch_q][j] = hist_q[ch_q][j-1];
                        end
                        hist_d[ch_q][0] = dat_in;
                        if (ch_q == CHW'(NCH-1)) begin
                            ch_d = '0;
                            ph_d = ~ph_q;
                        end else begin
                            ch_d = ch_q + CHW'(1);
                        end
                        if (ph_q) begin
                            bmode_d = 1'b0;
                            acc_d   = '0;
                            k_d     = '0;
                            rdy_d   = 1'b0;
                            state_d = ST_MAC;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MAC: begin
                acc_d = acc_q + AW'(prod_s);
                if (k_q == KW'(NSYM)) begin
                    state_d = ST_OUT;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            ST_BYP: begin
                state_d = ST_OUT;
            end
            ST_OUT: begin
                vld_d   = 1'b1;
                rdy_d   = 1'b1;
                cho_d   = mch_q;
                state_d = ST_IDLE;
                if (bmode_q) begin
                    dat_d = bdat_q;
                    sat_d = 1'b0;
                end else if (rnd_s > MAXV) begin
                    dat_d = DW'(MAXV);
                    sat_d = 1'b1;
                end else if (rnd_s < MINV) begin
                    dat_d = DW'(MINV);
                    sat_d = 1'b1;
                end else begin
                    dat_d = DW'(rnd_s);
                    sat_d = 1'b0;
                end
            end
            default: begin
                rdy_d   = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            rdy_q   <= 1'b1;
            k_q     <= '0;
            acc_q   <= '0;
            ch_q    <= '0;
            mch_q   <= '0;
            cho_q   <= '0;
            ph_q    <= 1'b0;
            bmode_q <= 1'b0;
            bdat_q  <= '0;
            dat_q   <= '0;
            sat_q   <= 1'b0;
            vld_q   <= 1'b0;
            for (int c = 0; c < HN; c++) begin
                for (int j = 0; j < L; j++) begin
                    hist_q[c][j] <= '0;
                end
            end
        end else begin
            state_q <= state_d;
            rdy_q   <= rdy_d;
            k_q     <= k_d;
            acc_q   <= acc_d;
            ch_q    <= ch_d;
            mch_q   <= mch_d;
            cho_q   <= cho_d;
            ph_q    <= ph_d;
            bmode_q <= bmode_d;
            bdat_q  <= bdat_d;
            dat_q   <= dat_d;
            sat_q   <= sat_d;
            vld_q   <= vld_d;
            hist_q  <= hist_d;
        end
    end

    assign vld_out = vld_q;
    assign dat_out = dat_q;
    assign ch_out  = cho_q;
    assign sat_out = sat_q;

endmodule
